comb_sweep_ctrl: RTL and testbench

- Sequencer and checker for the 3-input / 3-output combinational circuit under test.
- On start, drives every input vector {x,y,z} = 0..7 in order and waits a settle time after each one.
- Samples {F1,F2,F3} for each vector, stores it in an 8-entry result buffer and compares it against a parameterised expected truth table.
- Reports mismatch count, first failing vector and pass/fail through a start/busy/done handshake. Used for on-chip self-check of the circuit.

---
 rtl/comb_sweep_ctrl.sv | 162 ++++++++++++++++
 tb/tb_comb_sweep_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl: steps a 3-input combinational circuit through all eight
// input vectors. Each response is captured into a small result buffer and
// checked against an expected truth table. Results are reported through
// start/busy/done.
//
// Handshake: start is sampled only in IDLE, and abort wins if both are high.
// busy rises on the accepting edge and stays high through APPLY, SAMPLE and
// DONE. On the edge that leaves DONE, busy falls and done pulses for one cycle.
// pass, err_cnt, fail_seen and first_fail are also stable from that edge.
// An abort in APPLY or SAMPLE drops busy on the next edge and gives no done
// pulse.
module comb_sweep_ctrl #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [23:0] EXP_TABLE     = 24'hE94520
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] f_in,
  output logic [2:0] vec_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic       fail_seen,
  output logic [2:0] first_fail,
  input  logic [2:0] rd_addr,
  output logic [2:0] rd_data,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter reload so that APPLY lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [2:0] r_vec;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic       r_fail_seen;
  logic [2:0] r_first;
  logic [2:0] r_res [8];
  logic [2:0] w_exp_tab [8];
  logic       w_mismatch;

  // Unpack the expected truth table into one {F1,F2,F3} entry per vector.
  for (genvar g = 0; g < 8; g++) begin : g_exp
    assign w_exp_tab[g] = EXP_TABLE[3*g +: 3];
  end

  assign w_mismatch = (f_in != w_exp_tab[r_idx]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; abort only matters while a sweep is running.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start && !abort) w_next = S_APPLY;
      S_APPLY:  if (abort) w_next = S_IDLE;
                else if (r_cnt == 4'd0) w_next = S_SAMPLE;
      S_SAMPLE: if (abort) w_next = S_IDLE;
                else if (r_idx == 3'd7) w_next = S_DONE;
                else w_next = S_APPLY;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Sweep datapath: vector drive, settle counter, scoring and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= 3'd0;
      r_cnt       <= 4'd0;
      r_vec       <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= 4'd0;
      r_fail_seen <= 1'b0;
      r_first     <= 3'd0;
      for (int i = 0; i < 8; i++) r_res[i] <= 3'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_idx       <= 3'd0;
            r_vec       <= 3'd0;
            r_cnt       <= RELOAD;
            r_err       <= 4'd0;
            r_fail_seen <= 1'b0;
            r_first     <= 3'd0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_APPLY: begin
          if (abort) begin
            r_busy <= 1'b0;
            r_pass <= 1'b0;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            r_busy <= 1'b0;
            r_pass <= 1'b0;
          end else begin
            r_res[r_idx] <= f_in;
            if (w_mismatch) begin
              r_err <= r_err + 4'd1;
              if (!r_fail_seen) begin
                r_first     <= r_idx;
                r_fail_seen <= 1'b1;
              end
            end
            if (r_idx != 3'd7) begin
              r_idx <= r_idx + 3'd1;
              r_vec <= r_idx + 3'd1;
              r_cnt <= RELOAD;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_pass <= (r_err == 4'd0);
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign vec_out    = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign fail_seen  = r_fail_seen;
  assign first_fail = r_first;
  assign rd_data    = r_res[rd_addr];
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: table of fault models, random circuits scored by
// a truth-table reference, and hand sequences for abort/restart/reset.
module tb_comb_sweep_ctrl;

  localparam int S   = 2;
  localparam int LAT = 8 * (S + 1) + 1;

  logic       clk, rst, start, abort;
  logic [2:0] f_in, vec_out, first_fail, rd_addr, rd_data;
  logic       busy, done, pass, fail_seen;
  logic [3:0] err_cnt;
  logic [1:0] dbg_state;

  logic [2:0] circ_tab [8];
  logic [8:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] vec_seen [$];

  comb_sweep_ctrl #(.SETTLE_CYCLES(S), .EXP_TABLE(24'hE94520)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .f_in(f_in),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_seen(fail_seen), .first_fail(first_fail),
    .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Circuit under test: combinational lookup from the driven vector.
  always_comb f_in = circ_tab[vec_out];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: parity / majority / AND from the vector's bits.
  function automatic logic [2:0] ref_f(input int k);
    logic [2:0] v;
    int ones;
    v = k[2:0];
    ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return {^v, (ones >= 2), (v == 3'b111)};
  endfunction

  task automatic set_circuit(input int mode);
    logic [2:0] t;
    for (int k = 0; k < 8; k++) begin
      t = ref_f(k);
      case (mode)
        1: t[0] = 1'b1;
        2: if (k == 5) t = 3'b000;
        3: t[2] = ~t[2];
        default: ;
      endcase
      circ_tab[k] = t;
    end
  endtask

  // Pulse start, then count edges after the start edge until done is seen.
  task automatic run_sweep(output int lat);
    vec_seen.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    vec_seen.push_back(vec_out);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy && vec_out != vec_seen[$]) vec_seen.push_back(vec_out);
    end
  endtask

  task automatic check_vec_seq(input string name);
    logic ok;
    ok = (vec_seen.size() == 8);
    for (int i = 0; i < vec_seen.size() && i < 8; i++)
      if (vec_seen[i] != 3'(i)) ok = 1'b0;
    check(name, ok, 1);
  endtask

  task automatic wait_vec(input logic [2:0] v);
    int n;
    n = 0;
    while (vec_out != v && n < 100) begin @(negedge clk); n++; end
    check("wait_vec_timeout", (n < 100), 1);
  endtask

  typedef struct {
    int         mode;
    logic       pass;
    logic [3:0] err;
    logic       fs;
    logic [2:0] ff;
    logic [2:0] rd_addr;
    logic [2:0] rd_exp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int lat, ndone, e;
    logic [2:0] ff;
    logic [8:0] got, want;

    tbl[0] = '{0, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7, 3'b111};
    tbl[1] = '{1, 1'b0, 4'd7, 1'b1, 3'd0, 3'd3, 3'b011};
    tbl[2] = '{2, 1'b0, 4'd1, 1'b1, 3'd5, 3'd5, 3'b000};
    tbl[3] = '{3, 1'b0, 4'd8, 1'b1, 3'd0, 3'd0, 3'b100};

    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_addr = 3'd0;
    set_circuit(0);
    repeat (3) @(negedge clk);
    check("rst_vec", vec_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_cnt, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a); #1;
      check("rst_rd", rd_data, 0);
    end

    // Table-driven fault models
    for (int t = 0; t < 4; t++) begin
      set_circuit(tbl[t].mode);
      run_sweep(lat);
      check("tbl_latency", lat, LAT);
      check("tbl_pass", pass, tbl[t].pass);
      check("tbl_err", err_cnt, tbl[t].err);
      check("tbl_fs", fail_seen, tbl[t].fs);
      check("tbl_ff", first_fail, tbl[t].ff);
      check("tbl_busy", busy, 0);
      check_vec_seq("tbl_vec_seq");
      rd_addr = tbl[t].rd_addr; #1;
      check("tbl_rd", rd_data, tbl[t].rd_exp);
      @(negedge clk);
      check("tbl_done_pulse", done, 0);
      check("tbl_vec_hold", vec_out, 7);
    end

    // Random circuits scored by the reference
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++)
        circ_tab[k] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : ref_f(k);
      e = 0; ff = 3'd0;
      for (int k = 0; k < 8; k++)
        if (circ_tab[k] != ref_f(k)) begin
          if (e == 0) ff = 3'(k);
          e++;
        end
      exp_q.push_back({(e == 0), (e != 0), 4'(e), ff});
      run_sweep(lat);
      check("rnd_latency", lat, LAT);
      got  = {pass, fail_seen, err_cnt, first_fail};
      want = exp_q.pop_front();
      check("rnd_summary", got, want);
      for (int a = 0; a < 8; a++) begin
        rd_addr = 3'(a); #1;
        check("rnd_rd", rd_data, circ_tab[a]);
      end
    end

    // Abort mid-sweep with a faulty circuit, then a clean sweep
    set_circuit(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(3'd3);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err_kept", err_cnt, 3);
    check("abort_ff_kept", first_fail, 0);
    check("abort_fs_kept", fail_seen, 1);
    check("abort_pass", pass, 0);
    ndone = 0;
    repeat (30) begin @(negedge clk); if (done) ndone++; end
    check("abort_no_done", ndone, 0);
    set_circuit(0);
    run_sweep(lat);
    check("restart_latency", lat, LAT);
    check("restart_pass", pass, 1);
    check("restart_err", err_cnt, 0);

    // Abort during SAMPLE must not write that sample
    set_circuit(3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    e = 0;
    while (dbg_state != 2'd2 && e < 50) begin @(negedge clk); e++; end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("sample_abort_busy", busy, 0);
    check("sample_abort_err", err_cnt, 0);
    rd_addr = 3'd0; #1;
    check("sample_abort_rd", rd_data, 3'b000);

    // start during the sweep and in the DONE cycle is ignored
    set_circuit(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0; ndone = 0; e = -1;
    repeat (40) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (done) begin ndone++; if (e < 0) e = lat; end
      if ((vec_out == 3'd4 && dbg_state == 2'd1) || dbg_state == 2'd3) start = 1'b1;
    end
    start = 1'b0;
    check("restart_ignored_count", ndone, 1);
    check("restart_ignored_lat", e, LAT);
    check("restart_ignored_pass", pass, 1);

    // Asynchronous reset mid-sweep
    set_circuit(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(3'd6);
    #2 rst = 1'b1;
    #1;
    check("arst_vec", vec_out, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err_cnt, 0);
    check("arst_fs", fail_seen, 0);
    check("arst_ff", first_fail, 0);
    check("arst_pass", pass, 0);
    check("arst_done", done, 0);
    check("arst_state", dbg_state, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_state", dbg_state, 0);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a); #1;
      check("post_rst_rd", rd_data, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
